// File: rtl/exec_wb_unit_pkg.sv
`default_nettype none
// exec_wb_unit_pkg: opcode encodings, FSM state type and default widths
// Revision: 1.0
package exec_wb_unit_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 2;
    localparam int OP_W_DEF   = 3;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_NOP = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_WB   = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/exec_wb_unit_seq_mul16.sv
`default_nettype none
// seq_mul16: 16-iteration shift-add multiplier, 32-bit product
// Revision: 1.0
module seq_mul16 (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    output logic        last_o,
    output logic [31:0] product_o
);

    logic [31:0] p_q;
    logic [31:0] m_q;
    logic [15:0] q_q;
    logic [3:0]  cnt_q;
    logic        run_q;
    logic [31:0] p_d;

    // Product including the iteration in flight, so the final value is ready on the last edge
    assign p_d       = p_q + (q_q[0] ? m_q : 32'd0);
    assign product_o = p_d;
    assign last_o    = run_q && (cnt_q == 4'd15);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p_q   <= 32'd0;
            m_q   <= 32'd0;
            q_q   <= 16'd0;
            cnt_q <= 4'd0;
            run_q <= 1'b0;
        end else if (start_i) begin
            p_q   <= 32'd0;
            m_q   <= {16'd0, a_i};
            q_q   <= b_i;
            cnt_q <= 4'd0;
            run_q <= 1'b1;
        end else if (run_q) begin
            p_q   <= p_d;
            m_q   <= m_q << 1;
            q_q   <= q_q >> 1;
            cnt_q <= cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
                run_q <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/exec_wb_unit.sv
`default_nettype none
// exec_wb_unit: execute/write-back stage feeding a 4x16 register file
// Revision: 1.0
module exec_wb_unit
    import exec_wb_unit_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int OP_W   = OP_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [OP_W-1:0]   instr_op,
    input  logic [ADDR_W-1:0] instr_rd,
    input  logic [ADDR_W-1:0] instr_rs1,
    input  logic [ADDR_W-1:0] instr_rs2,
    output logic [ADDR_W-1:0] r_add1,
    output logic [ADDR_W-1:0] r_add2,
    input  logic [DATA_W-1:0] r_data1,
    input  logic [DATA_W-1:0] r_data2,
    output logic [ADDR_W-1:0] w_add,
    output logic              w_flag,
    output logic [DATA_W-1:0] w_data,
    output logic              done,
    output logic              busy,
    output logic              flag_z,
    output logic              flag_c
);

    state_e              state_q;
    logic [ADDR_W-1:0]   rd_q;
    logic [ADDR_W-1:0]   w_add_q;
    logic                w_flag_q;
    logic [DATA_W-1:0]   w_data_q;
    logic                done_q;
    logic                flag_z_q;
    logic                flag_c_q;

    logic [DATA_W-1:0]   alu_res_d;
    logic                alu_c_d;
    logic [DATA_W:0]     sum_d;
    logic                accept_d;
    logic                mul_start_d;
    logic                mul_last;
    logic [31:0]         mul_prod;

    assign r_add1      = instr_rs1;
    assign r_add2      = instr_rs2;
    assign instr_ready = (state_q == ST_IDLE) && reset;
    assign busy        = (state_q != ST_IDLE);
    assign w_add       = w_add_q;
    assign w_flag      = w_flag_q;
    assign w_data      = w_data_q;
    assign done        = done_q;
    assign flag_z      = flag_z_q;
    assign flag_c      = flag_c_q;

    assign accept_d    = (state_q == ST_IDLE) && instr_valid;
    assign mul_start_d = accept_d && (instr_op == OP_MUL);

    always_comb begin
        alu_res_d = '0;
        alu_c_d   = 1'b0;
        sum_d     = '0;
        case (instr_op)
            OP_ADD: begin
                sum_d     = {1'b0, r_data1} + {1'b0, r_data2};
                alu_res_d = sum_d[DATA_W-1:0];
                alu_c_d   = sum_d[DATA_W];
            end
            OP_SUB: begin
                alu_res_d = r_data1 - r_data2;
                alu_c_d   = (r_data1 >= r_data2);
            end
            OP_AND:  alu_res_d = r_data1 & r_data2;
            OP_OR:   alu_res_d = r_data1 | r_data2;
            OP_XOR:  alu_res_d = r_data1 ^ r_data2;
            OP_SHL:  alu_res_d = r_data1 << r_data2[3:0];
            default: alu_res_d = '0;
        endcase
    end

    seq_mul16 u_mul (
        .clk       (clk),
        .reset     (reset),
        .start_i   (mul_start_d),
        .a_i       (r_data1),
        .b_i       (r_data2),
        .last_o    (mul_last),
        .product_o (mul_prod)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            rd_q     <= '0;
            w_add_q  <= '0;
            w_flag_q <= 1'b0;
            w_data_q <= '0;
            done_q   <= 1'b0;
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
        end else begin
            w_flag_q <= 1'b0;
            done_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (instr_valid) begin
                        rd_q <= instr_rd;
                        if (instr_op == OP_MUL) begin
                            state_q <= ST_MUL;
                        end else begin
                            // ALU result is final at the accept edge; go straight to write-back
                            state_q  <= ST_WB;
                            w_add_q  <= instr_rd;
                            w_data_q <= alu_res_d;
                            w_flag_q <= (instr_op != OP_NOP);
                            done_q   <= 1'b1;
                            if (instr_op != OP_NOP) begin
                                flag_z_q <= (alu_res_d == '0);
                                flag_c_q <= alu_c_d;
                            end
                        end
                    end
                end
                ST_MUL: begin
                    if (mul_last) begin
                        state_q  <= ST_WB;
                        w_add_q  <= rd_q;
                        w_data_q <= mul_prod[DATA_W-1:0];
                        w_flag_q <= 1'b1;
                        done_q   <= 1'b1;
                        flag_z_q <= (mul_prod[DATA_W-1:0] == '0);
                        flag_c_q <= (mul_prod[31:16] != 16'd0);
                    end
                end
                ST_WB: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_exec_wb_unit.sv
`default_nettype none
// tb_exec_wb_unit: directed + random checks of exec_wb_unit against an arithmetic model
// Revision: 1.0
module tb_exec_wb_unit;

    localparam logic [2:0] T_ADD = 3'b000;
    localparam logic [2:0] T_SUB = 3'b001;
    localparam logic [2:0] T_XOR = 3'b100;
    localparam logic [2:0] T_SHL = 3'b101;
    localparam logic [2:0] T_MUL = 3'b110;
    localparam logic [2:0] T_NOP = 3'b111;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [2:0]  instr_op = 3'b111;
    logic [1:0]  instr_rd = 2'd0;
    logic [1:0]  instr_rs1 = 2'd0;
    logic [1:0]  instr_rs2 = 2'd0;
    logic [1:0]  r_add1;
    logic [1:0]  r_add2;
    logic [15:0] r_data1;
    logic [15:0] r_data2;
    logic [1:0]  w_add;
    logic        w_flag;
    logic [15:0] w_data;
    logic        done;
    logic        busy;
    logic        flag_z;
    logic        flag_c;

    logic [15:0] rf [4];
    logic [15:0] mrf [4];
    logic        pre_we = 1'b0;
    logic [1:0]  pre_idx = 2'd0;
    logic [15:0] pre_val = 16'd0;
    logic        exp_z = 1'b0;
    logic        exp_c = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    exec_wb_unit dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_op    (instr_op),
        .instr_rd    (instr_rd),
        .instr_rs1   (instr_rs1),
        .instr_rs2   (instr_rs2),
        .r_add1      (r_add1),
        .r_add2      (r_add2),
        .r_data1     (r_data1),
        .r_data2     (r_data2),
        .w_add       (w_add),
        .w_flag      (w_flag),
        .w_data      (w_data),
        .done        (done),
        .busy        (busy),
        .flag_z      (flag_z),
        .flag_c      (flag_c)
    );

    // Register file: combinational reads, writes on the falling edge
    assign r_data1 = rf[r_add1];
    assign r_data2 = rf[r_add2];
    always @(negedge clk) begin
        if (w_flag) rf[w_add] <= w_data;
        else if (pre_we) rf[pre_idx] <= pre_val;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] r, output logic c);
        int unsigned s;
        longint unsigned p;
        s = 0;
        p = 0;
        r = 16'd0;
        c = 1'b0;
        case (op)
            3'b000: begin s = a + b; r = s[15:0]; c = (s > 32'd65535); end
            3'b001: begin s = a - b; r = s[15:0]; c = (a >= b); end
            3'b010: r = a & b;
            3'b011: r = a | b;
            3'b100: r = a ^ b;
            3'b101: begin s = {16'd0, a} << (b % 16); r = s[15:0]; end
            3'b110: begin p = longint'(a) * longint'(b); r = p[15:0]; c = (p > 64'd65535); end
            default: r = 16'd0;
        endcase
    endtask

    task automatic set_reg(input logic [1:0] idx, input logic [15:0] val);
        @(posedge clk);
        #1;
        pre_we  = 1'b1;
        pre_idx = idx;
        pre_val = val;
        @(negedge clk);
        #1;
        pre_we  = 1'b0;
        mrf[idx] = val;
    endtask

    task automatic check_rf(input string tag);
        for (int i = 0; i < 4; i++) chk(tag, rf[i], mrf[i]);
    endtask

    task automatic run_instr(input string tag, input logic [2:0] op, input logic [1:0] rd,
                             input logic [1:0] rs1, input logic [1:0] rs2);
        logic [15:0] er;
        logic        ec;
        logic        wr;
        bit          seen;
        int          lat;
        model(op, mrf[rs1], mrf[rs2], er, ec);
        wr  = (op != T_NOP);
        lat = (op == T_MUL) ? 17 : 1;
        @(negedge clk);
        chk({tag, "_ready"}, instr_ready, 1);
        instr_op    = op;
        instr_rd    = rd;
        instr_rs1   = rs1;
        instr_rs2   = rs2;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        seen = 0;
        if (wr) begin
            exp_z = (er == 16'd0);
            exp_c = ec;
        end
        for (int n = 1; n <= 40 && !seen; n++) begin
            @(negedge clk);
            chk({tag, "_busy"}, busy, 1);
            if (done) begin
                seen = 1;
                chk({tag, "_latency"}, n, lat);
                chk({tag, "_wflag"}, w_flag, wr);
                if (wr) begin
                    chk({tag, "_wadd"}, w_add, rd);
                    chk({tag, "_wdata"}, w_data, er);
                end
                chk({tag, "_z"}, flag_z, exp_z);
                chk({tag, "_c"}, flag_c, exp_c);
            end
        end
        chk({tag, "_done_seen"}, seen, 1);
        if (wr) mrf[rd] = er;
        @(negedge clk);
        chk({tag, "_done_clr"}, done, 0);
        chk({tag, "_wflag_clr"}, w_flag, 0);
        chk({tag, "_idle"}, instr_ready, 1);
        check_rf({tag, "_rf"});
    endtask

    initial begin
        logic [15:0] e1, e2;
        logic        c1, c2;
        int          dcount;
        int          wcount;

        for (int i = 0; i < 4; i++) mrf[i] = 16'd0;
        // Reset state
        #12;
        chk("rst_wflag", w_flag, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wdata", w_data, 0);
        chk("rst_wadd", w_add, 0);
        chk("rst_z", flag_z, 0);
        chk("rst_c", flag_c, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_ready", instr_ready, 1);
        for (int i = 0; i < 4; i++) set_reg(i[1:0], 16'd0);

        // ADD with carry out and zero result
        set_reg(2'd1, 16'hFFFF);
        set_reg(2'd2, 16'h0001);
        run_instr("add", T_ADD, 2'd3, 2'd1, 2'd2);
        chk("add_z_const", flag_z, 1);
        chk("add_c_const", flag_c, 1);

        // SUB with borrow, then equal operands
        set_reg(2'd1, 16'h0005);
        set_reg(2'd2, 16'h0007);
        run_instr("sub", T_SUB, 2'd0, 2'd1, 2'd2);
        chk("sub_val", rf[0], 16'hFFFE);
        run_instr("sub_eq", T_SUB, 2'd3, 2'd2, 2'd2);
        chk("sub_eq_z", flag_z, 1);
        chk("sub_eq_c", flag_c, 1);

        // MUL: overflow into upper half, then small product
        set_reg(2'd1, 16'h0123);
        set_reg(2'd2, 16'h0100);
        run_instr("mul", T_MUL, 2'd2, 2'd1, 2'd2);
        chk("mul_val", rf[2], 16'h2300);
        set_reg(2'd1, 16'h0003);
        set_reg(2'd2, 16'h0005);
        run_instr("mul_small", T_MUL, 2'd0, 2'd1, 2'd2);
        chk("mul_small_val", rf[0], 16'h000F);

        // NOP leaves flags alone; SHL uses only the low 4 bits of B
        run_instr("nop", T_NOP, 2'd3, 2'd0, 2'd1);
        set_reg(2'd1, 16'h8001);
        set_reg(2'd2, 16'h0011);
        run_instr("shl", T_SHL, 2'd3, 2'd1, 2'd2);
        chk("shl_val", rf[3], 16'h0002);

        // Back-to-back dependent pair with instr_valid held high
        set_reg(2'd1, 16'h1234);
        set_reg(2'd2, 16'h1111);
        model(T_ADD, mrf[1], mrf[2], e1, c1);
        model(T_XOR, e1, e1, e2, c2);
        dcount = 0;
        @(negedge clk);
        instr_op = T_ADD; instr_rd = 2'd1; instr_rs1 = 2'd1; instr_rs2 = 2'd2;
        instr_valid = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (done) dcount++;
            if (k == 1) begin
                chk("b2b_first_done", done, 1);
                chk("b2b_first_data", w_data, e1);
                instr_op = T_XOR; instr_rd = 2'd0; instr_rs1 = 2'd1; instr_rs2 = 2'd1;
            end
            if (k == 3) begin
                chk("b2b_second_done", done, 1);
                chk("b2b_second_data", w_data, e2);
                chk("b2b_second_z", flag_z, 1);
                instr_valid = 1'b0;
            end
        end
        chk("b2b_accepts", dcount, 2);
        mrf[1] = e1;
        mrf[0] = e2;
        exp_z = 1'b1;
        exp_c = c2;
        check_rf("b2b_rf");

        // Reset in the middle of a MUL aborts it
        @(negedge clk);
        instr_op = T_MUL; instr_rd = 2'd2; instr_rs1 = 2'd1; instr_rs2 = 2'd1;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        repeat (8) @(negedge clk);
        chk("mulrst_busy_before", busy, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("mulrst_wflag", w_flag, 0);
        chk("mulrst_done", done, 0);
        chk("mulrst_busy", busy, 0);
        chk("mulrst_z", flag_z, 0);
        chk("mulrst_c", flag_c, 0);
        exp_z = 1'b0;
        exp_c = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        wcount = 0;
        @(negedge clk);
        chk("mulrst_ready", instr_ready, 1);
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (w_flag || done) wcount++;
        end
        chk("mulrst_no_write", wcount, 0);
        check_rf("mulrst_rf");

        // Random instructions against the model
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 3) == 0) set_reg(2'($urandom_range(0, 3)), 16'($urandom));
            run_instr("rand", 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                      2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
